// File: rtl/uart_rx_decimator.sv
// Decimates the uart_rx byte stream by 2^DECIM_LOG2 (mean or first sample)
// and feeds the results to uart_tx through a small FIFO with a DV/Done handshake.
module uart_rx_decimator #(
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned MODE       = 0,
  parameter int unsigned FIFO_LOG2  = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  output logic [FIFO_LOG2:0]   o_Fifo_Count,
  output logic                 o_Overflow
);

  localparam int unsigned M     = 32'd1 << DECIM_LOG2;
  localparam int unsigned IDX_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int unsigned ACC_W = 8 + DECIM_LOG2;
  localparam int unsigned DEPTH = 32'd1 << FIFO_LOG2;
  localparam int unsigned PTR_W = (FIFO_LOG2 > 0) ? FIFO_LOG2 : 1;
  localparam int unsigned CNT_W = FIFO_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [7:0]         first;
  logic [7:0]         result;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               grp_last, push_req, push_ok, pop, full, empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Group arithmetic and FIFO push/pop decisions for the current cycle.
  always_comb begin
    grp_last = (idx == IDX_W'(M - 1));
    acc_next = (idx == '0) ? ACC_W'(i_Rx_Byte) : acc + ACC_W'(i_Rx_Byte);
    if (MODE == 1) result = (idx == '0) ? i_Rx_Byte : first;
    else           result = 8'(acc_next >> DECIM_LOG2);
    full     = (o_Fifo_Count == CNT_W'(DEPTH));
    empty    = (o_Fifo_Count == '0);
    pop      = (state == IDLE) && !empty && !i_Tx_Active;
    push_req = i_Rx_DV && grp_last;
    // A full FIFO can still accept when the head leaves on the same edge.
    push_ok  = push_req && (!full || pop);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = SEND;
      SEND:    state_next = WAIT;
      WAIT:    if (i_Tx_Done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_next;
  end

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr] <= result;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      idx          <= '0;
      acc          <= '0;
      first        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_Fifo_Count <= '0;
      o_Tx_DV      <= 1'b0;
      o_Tx_Byte    <= '0;
      o_Overflow   <= 1'b0;
    end else begin
      o_Tx_DV <= pop;
      if (i_Rx_DV) begin
        idx <= grp_last ? '0 : idx + IDX_W'(1);
        acc <= acc_next;
        if (idx == '0) first <= i_Rx_Byte;
      end
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (push_req && !push_ok) o_Overflow <= 1'b1;
      if (pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        o_Tx_Byte <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   o_Fifo_Count <= o_Fifo_Count + CNT_W'(1);
        2'b01:   o_Fifo_Count <= o_Fifo_Count - CNT_W'(1);
        default: o_Fifo_Count <= o_Fifo_Count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_decimator.sv
// Bench for uart_rx_decimator: an average-mode and a first-sample-mode instance
// share the rx stream, each with its own uart_tx stand-in and list-based model.
module tb_uart_rx_decimator;

  localparam int M     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            rx_dv = 1'b0;
  logic [7:0]      rx_byte = 8'h00;
  logic [1:0]      hold = 2'b00;
  logic            manual = 1'b0;
  logic            man_active = 1'b0;
  logic            man_done = 1'b0;
  int              tx_lo = 6, tx_hi = 6;

  logic [1:0]      emu_active = 2'b00, emu_done = 2'b00;
  int              emu_rem [2];
  logic [1:0]      tx_active, tx_done;
  logic [1:0]      dv_o, ovf_o;
  logic [1:0][7:0] byte_o;
  logic [1:0][2:0] cnt_o;

  assign tx_active = manual ? {2{man_active}} : emu_active;
  assign tx_done   = manual ? {2{man_done}}   : emu_done;

  uart_rx_decimator #(.DECIM_LOG2(2), .MODE(0), .FIFO_LOG2(2)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_Tx_Active(tx_active[0]), .i_Tx_Done(tx_done[0]),
    .o_Tx_DV(dv_o[0]), .o_Tx_Byte(byte_o[0]), .o_Fifo_Count(cnt_o[0]), .o_Overflow(ovf_o[0]));

  uart_rx_decimator #(.DECIM_LOG2(2), .MODE(1), .FIFO_LOG2(2)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_Tx_Active(tx_active[1]), .i_Tx_Done(tx_done[1]),
    .o_Tx_DV(dv_o[1]), .o_Tx_Byte(byte_o[1]), .o_Fifo_Count(cnt_o[1]), .o_Overflow(ovf_o[1]));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // uart_tx stand-in: busy for a random number of cycles, then a Done pulse.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      emu_done[u] = 1'b0;
      if (dv_o[u]) begin
        emu_active[u] = 1'b1;
        emu_rem[u]    = $urandom_range(tx_hi, tx_lo);
      end else if (emu_active[u] && !hold[u]) begin
        if (emu_rem[u] == 0) begin
          emu_done[u]   = 1'b1;
          emu_active[u] = 1'b0;
        end else emu_rem[u]--;
      end
    end
  end

  // Reference: groups of M bytes -> mean or first; a list of queued results;
  // one byte handed out per Done when uart_tx is free.
  int         m_idx [2], m_sum [2], m_first [2], m_n [2];
  logic [7:0] m_list [2][DEPTH];
  logic       m_busy [2], m_dv [2], m_ovf [2];
  logic [7:0] m_byte [2];
  logic       armed = 1'b0;
  logic       mp;
  logic [7:0] mh;
  int         mr;

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_idx[u] = 0; m_sum[u] = 0; m_first[u] = 0; m_n[u] = 0;
        m_busy[u] = 1'b0; m_dv[u] = 1'b0; m_ovf[u] = 1'b0; m_byte[u] = 8'h00;
        armed = 1'b1;
      end else begin
        mp = !m_busy[u] && (m_n[u] > 0) && !tx_active[u];
        mh = m_list[u][0];
        if (mp) begin
          for (int i = 0; i < DEPTH - 1; i++) m_list[u][i] = m_list[u][i+1];
          m_n[u]--;
        end
        if (m_busy[u] && !m_dv[u] && tx_done[u]) m_busy[u] = 1'b0;
        if (mp) begin
          m_busy[u] = 1'b1;
          m_byte[u] = mh;
        end
        m_dv[u] = mp;
        if (rx_dv) begin
          if (m_idx[u] == 0) begin
            m_sum[u]   = int'(rx_byte);
            m_first[u] = int'(rx_byte);
          end else m_sum[u] += int'(rx_byte);
          if (m_idx[u] == M - 1) begin
            mr = (u == 0) ? m_sum[u] / M : m_first[u];
            m_idx[u] = 0;
            if (m_n[u] < DEPTH) begin
              m_list[u][m_n[u]] = 8'(mr);
              m_n[u]++;
            end else m_ovf[u] = 1'b1;
          end else m_idx[u]++;
        end
      end
    end
  end

  logic [7:0] got0 [$];
  logic [7:0] got1 [$];

  // Per-cycle comparison against the model, plus a log of transmitted bytes.
  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("dv%0d", u),    32'(dv_o[u]),   32'(m_dv[u]));
        chk($sformatf("byte%0d", u),  32'(byte_o[u]), 32'(m_byte[u]));
        chk($sformatf("count%0d", u), 32'(cnt_o[u]),  32'(m_n[u]));
        chk($sformatf("ovf%0d", u),   32'(ovf_o[u]),  32'(m_ovf[u]));
      end
      if (dv_o[0]) got0.push_back(byte_o[0]);
      if (dv_o[1]) got1.push_back(byte_o[1]);
    end
  end

  function automatic logic [7:0] g0(input int i);
    return (i < got0.size()) ? got0[i] : 8'hxx;
  endfunction
  function automatic logic [7:0] g1(input int i);
    return (i < got1.size()) ? got1[i] : 8'hxx;
  endfunction

  // Called just after a negedge; leaves rx_dv low unless gap is 0 and another call follows.
  task automatic rx(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic done_pulse();
    man_done = 1'b1; man_active = 1'b0;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
  endtask

  int n0, n1, dens;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("reset_dv",    32'(dv_o[u]),   32'd0);
      chk("reset_byte",  32'(byte_o[u]), 32'd0);
      chk("reset_count", 32'(cnt_o[u]),  32'd0);
      chk("reset_ovf",   32'(ovf_o[u]),  32'd0);
    end

    // Average of 10,20,30,40 with latency pinned
    n0 = got0.size(); n1 = got1.size();
    rx(8'h0A, 0); rx(8'h14, 0); rx(8'h1E, 0); rx(8'h28, 0);
    chk("lat_count1", 32'(cnt_o[0]), 32'd1);
    @(negedge clk);
    chk("lat_dv",     32'(dv_o[0]),   32'd1);
    chk("lat_byte",   32'(byte_o[0]), 32'h19);
    chk("lat_count0", 32'(cnt_o[0]),  32'd0);
    chk("lat_first",  32'(byte_o[1]), 32'h0A);
    repeat (20) @(negedge clk);
    chk("avg_n",   32'(got0.size() - n0), 32'd1);
    chk("avg_ovf", 32'(ovf_o[0]), 32'd0);

    // Truncation and full-scale width
    n0 = got0.size(); n1 = got1.size();
    rx(8'h01, 0); rx(8'h02, 0); rx(8'h02, 0); rx(8'h02, 0);
    rx(8'hFF, 0); rx(8'hFF, 0); rx(8'hFF, 0); rx(8'hFF, 0);
    repeat (40) @(negedge clk);
    chk("trunc",      32'(g0(n0)),     32'h01);
    chk("fullscale",  32'(g0(n0 + 1)), 32'hFF);
    chk("trunc_m1",   32'(g1(n1)),     32'h01);
    chk("full_m1",    32'(g1(n1 + 1)), 32'hFF);

    // First-sample mode, two back-to-back groups
    n0 = got0.size(); n1 = got1.size();
    for (int i = 1; i <= 8; i++) rx(8'(i * 8'h11), 0);
    repeat (40) @(negedge clk);
    chk("first_a", 32'(g1(n1)),     32'h11);
    chk("first_b", 32'(g1(n1 + 1)), 32'h55);
    chk("first_n", 32'(got1.size() - n1), 32'd2);
    chk("avg_a",   32'(g0(n0)),     32'h2A);
    chk("avg_b",   32'(g0(n0 + 1)), 32'h6E);

    // Overflow with uart_tx stuck busy
    n0 = got0.size();
    hold = 2'b11;
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < M; i++) rx(8'h08, 0);
      if (g == 4) begin
        chk("ovf_full",    32'(cnt_o[0]), 32'd4);
        chk("ovf_notyet",  32'(ovf_o[0]), 32'd0);
      end
    end
    chk("ovf_count", 32'(cnt_o[0]), 32'd4);
    chk("ovf_set",   32'(ovf_o[0]), 32'd1);
    chk("ovf_one",   32'(got0.size() - n0), 32'd1);
    hold = 2'b00;
    repeat (100) @(negedge clk);
    chk("ovf_drain_n", 32'(got0.size() - n0), 32'd5);
    for (int i = 0; i < 5; i++) chk("ovf_drain_byte", 32'(g0(n0 + i)), 32'h08);
    chk("ovf_sticky", 32'(ovf_o[0]), 32'd1);

    // Reset mid-group discards the partial group
    n0 = got0.size(); n1 = got1.size();
    rx(8'h80, 0); rx(8'h80, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < M; i++) rx(8'h04, 0);
    repeat (30) @(negedge clk);
    chk("rst_n",    32'(got0.size() - n0), 32'd1);
    chk("rst_byte", 32'(g0(n0)), 32'h04);
    chk("rst_m1",   32'(g1(n1)), 32'h04);
    chk("rst_ovf",  32'(ovf_o[0]), 32'd0);

    // Reset while waiting for Done; the later Done is stray
    n0 = got0.size();
    for (int i = 0; i < M; i++) rx(8'h09, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("stray_n",    32'(got0.size() - n0), 32'd1);
    chk("stray_byte", 32'(g0(n0)), 32'h09);

    // Push and pop on the same edge with the FIFO full
    n0 = got0.size(); n1 = got1.size();
    manual = 1'b1; man_active = 1'b0; man_done = 1'b0;
    for (int i = 0; i < M; i++) rx(8'h05, 0);
    @(negedge clk);
    man_active = 1'b1;
    for (int g = 6; g <= 9; g++) for (int i = 0; i < M; i++) rx(8'(g), 0);
    chk("coll_full", 32'(cnt_o[0]), 32'd4);
    for (int i = 0; i < M - 1; i++) rx(8'h0A, 0);
    man_done = 1'b1; man_active = 1'b0;
    @(negedge clk);
    man_done = 1'b0;
    rx(8'h0A, 0);
    chk("coll_dv",    32'(dv_o[0]),   32'd1);
    chk("coll_byte",  32'(byte_o[0]), 32'h06);
    chk("coll_count", 32'(cnt_o[0]),  32'd4);
    chk("coll_ovf",   32'(ovf_o[0]),  32'd0);
    man_active = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      man_done = 1'b1; man_active = 1'b0;
      @(negedge clk);
      man_done = 1'b0;
      @(negedge clk);
      man_active = 1'b1;
      @(negedge clk);
    end
    done_pulse();
    manual = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("coll_seq0", 32'(g0(n0 + i)), 32'(5 + i));
      chk("coll_seq1", 32'(g1(n1 + i)), 32'(5 + i));
    end
    repeat (20) @(negedge clk);

    // Random traffic, random uart_tx timing, occasional stalls and resets
    tx_lo = 0; tx_hi = 10;
    dens = 0;
    for (int it = 0; it < 3000; it++) begin
      if (it % 500 == 0) dens = $urandom_range(2, 0);
      rx_dv   = ($urandom_range((1 << dens) - 1, 0) == 0);
      rx_byte = 8'($urandom);
      if ($urandom_range(149, 0) == 0) hold[0] = ~hold[0];
      if ($urandom_range(149, 0) == 0) hold[1] = ~hold[1];
      rst = ($urandom_range(799, 0) == 0);
      @(negedge clk);
    end
    rx_dv = 1'b0; rst = 1'b0; hold = 2'b00;
    repeat (200) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
